// File: rtl/mux21_arbiter_pkg.sv
// Shared types and limits for the 2:1 arbitrated mux.
// Holds the FSM state enum and the hold-count range.
package mux21_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam int MAX_HOLD_LIMIT = 15;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mux21_arbiter_if.sv
// Requester/downstream bundle of the 2:1 arbitrated mux.
// master: requesters+sink side; slave: arbiter side.
interface mux21_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  sel;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output req0, req1, data0, data1, out_ready,
    input  gnt0, gnt1, sel, out_data, out_valid, busy
  );

  modport slave (
    input  req0, req1, data0, data1, out_ready,
    output gnt0, gnt1, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux21_arbiter_datapath.sv
// Unbuffered 2:1 data select: sel=0 -> data0, sel=1 -> data1.
// Ports: sel, data0, data1 in; out_data out.
module mux21_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] out_data
);
  assign out_data = sel ? data1 : data0;
endmodule

// File: rtl/mux21_arbiter.sv
// Two-requester arbiter driving a shared 2:1 mux, with a per-grant
// beat limit (MAX_HOLD) and round-robin contention resolution.
// Ports: clk, rst_n (async, active-low), bus (mux21_arbiter_if.slave).
// Build option: MUX21_ARB_FIXED_PRIO_EN makes req0 always win.
module mux21_arbiter
  import mux21_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux21_arbiter_if.slave  bus
);

  localparam int HOLD =
    (MAX_HOLD > MAX_HOLD_LIMIT) ? MAX_HOLD_LIMIT :
    (MAX_HOLD < 1) ? 1 : MAX_HOLD;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

  state_e           state;
  state_e           nxt;
  state_e           rel0_tgt;
  state_e           rel1_tgt;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             enter;
  logic             prefer0;
  logic             beat;
  logic             hold_done;
  logic             g0_q;
  logic             g1_q;
  logic             busy_q;

  assign bus.gnt0      = g0_q;
  assign bus.gnt1      = g1_q;
  assign bus.sel       = g1_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = (g0_q & bus.req0) | (g1_q & bus.req1);

  assign beat      = bus.out_valid & bus.out_ready;
  assign hold_done = beat && (cnt == LAST_CNT);

`ifdef MUX21_ARB_FIXED_PRIO_EN
  // req0 wins every decision, including re-grant on its own release.
  assign prefer0  = 1'b1;
  assign rel0_tgt = bus.req0 ? GNT0 : (bus.req1 ? GNT1 : IDLE);
  assign rel1_tgt = bus.req0 ? GNT0 : (bus.req1 ? GNT1 : IDLE);
`else
  // last_gnt=1 means req1 held the bus last, so req0 goes next.
  assign prefer0  = last_gnt;
  assign rel0_tgt = bus.req1 ? GNT1 : IDLE;
  assign rel1_tgt = bus.req0 ? GNT0 : IDLE;
`endif

  always_comb begin
    nxt   = state;
    enter = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || prefer0)) begin
          nxt   = GNT0;
          enter = 1'b1;
        end else if (bus.req1) begin
          nxt   = GNT1;
          enter = 1'b1;
        end
      end
      GNT0: begin
        if (!bus.req0 || hold_done) begin
          nxt   = rel0_tgt;
          enter = (rel0_tgt != IDLE);
        end
      end
      GNT1: begin
        if (!bus.req1 || hold_done) begin
          nxt   = rel1_tgt;
          enter = (rel1_tgt != IDLE);
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      g0_q     <= 1'b0;
      g1_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= nxt;
      g0_q   <= (nxt == GNT0);
      g1_q   <= (nxt == GNT1);
      busy_q <= (nxt != IDLE);
      if (enter) begin
        cnt      <= '0;
        last_gnt <= (nxt == GNT1);
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  mux21_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dp (
    .sel      (g1_q),
    .data0    (bus.data0),
    .data1    (bus.data1),
    .out_data (bus.out_data)
  );

endmodule

// File: doc/mux21_arbiter.md
MUX21_ARBITER -- requirements
Module: mux21_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each data path.
REQ-002 Parameter MAX_HOLD, default 4, range 1..15, SHALL set the maximum accepted beats per grant.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req0, req1  input  1 each  SHALL request the shared output.
REQ-006 data0, data1  input  DATA_WIDTH each  SHALL carry requester payloads.
REQ-007 gnt0, gnt1  output  1 each  SHALL indicate the current owner; never both high.
REQ-008 sel  output  1  SHALL drive the 2:1 mux select (0 = data0, 1 = data1).
REQ-009 out_data  output  DATA_WIDTH  SHALL equal data0 when sel=0, else data1.
REQ-010 out_valid  output  1  SHALL equal (gnt0 & req0) | (gnt1 & req1).
REQ-011 out_ready  input  1  SHALL be the downstream accept; beat = out_valid & out_ready.
REQ-012 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, GNT0, GNT1; gntN high only in GNTN, sel=1 only in GNT1.
REQ-014 IDLE with one request SHALL move to that requester's GNT state next cycle (1-cycle grant latency).
REQ-015 IDLE with both requests SHALL grant the requester not granted last (round-robin pointer last_gnt).
REQ-016 In GNTN, a hold counter SHALL increment on each beat and be frozen while out_ready is low.
REQ-017 Release SHALL occur when reqN is low, or a beat occurs with counter = MAX_HOLD-1.
REQ-018 On release, if the other requester is requesting, state SHALL switch directly to its GNT state; otherwise go to IDLE.
REQ-019 Counter SHALL clear to 0 on every grant entry; last_gnt SHALL update on every grant entry.
REQ-020 reqN dropping mid-burst SHALL release without counting a beat in that cycle.
REQ-021 MAX_HOLD=1 SHALL release after every single beat (alternation when both request).
REQ-022 Data SHALL not be buffered; out_data/out_valid are combinational from state and inputs.

Reset
REQ-023 On rst_n low: state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, busy=0, counter=0, last_gnt=1 (req0 wins first contention).
REQ-024 Reset asserted mid-burst SHALL drop grants immediately, without waiting for clk.

Configuration
REQ-025 Macro MUX21_ARB_FIXED_PRIO_EN defined: every arbitration decision (IDLE and release) SHALL favour req0; last_gnt is ignored; hold limit still applies.
REQ-026 Macro undefined: round-robin per REQ-015/REQ-018.

Structure
REQ-027 Package mux21_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and the MAX_HOLD range limit constant.
REQ-028 The select/data path SHALL be one sub-module, mux21_datapath (sel, data0, data1 -> out_data); the FSM stays in mux21_arbiter.

Verification
REQ-029 Reset, then req0=1 only, out_ready=1, data0=8'hA5 -> gnt0=1 after 1 cycle, out_data=8'hA5, release after 4 beats, re-grant gnt0 next cycle.
REQ-030 Both requests from IDLE after reset -> GNT0 for 4 beats, then GNT1 for 4 beats, alternating; never both grants high.
REQ-031 GNT1, out_ready=0 for 6 cycles -> counter frozen, gnt1 held, no switch; then out_ready=1 -> release after remaining beats.
REQ-032 GNT0 with req0 dropped after 2 beats, req1=1 -> gnt1 next cycle, no IDLE cycle.
REQ-033 rst_n low during GNT1 -> gnt1, busy, out_valid low immediately; next contention grants req0.
REQ-034 MUX21_ARB_FIXED_PRIO_EN defined, both requesting continuously -> gnt0 re-granted after each 4-beat release; gnt1 never asserted.
